// File: rtl/histogram_sequencer.sv
// Frame controller for the pixel histogram: CLEAR -> ACCUM -> FLUSH -> DRAIN over one count table.
// Optional: define HIST_SKIP_ZERO_EN to drop zero-count bins from the drain stream.
module histogram_sequencer #(
  parameter int TABLE_SIZE  = 256,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 32,
  localparam int IDX_W      = $clog2(TABLE_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n_in,
  input  logic                   start_in,
  input  logic [DATA_WIDTH-1:0]  pix_in,
  input  logic                   pix_valid_in,
  input  logic                   pix_last_in,
  output logic                   pix_ready_out,
  output logic [IDX_W-1:0]       bin_idx_out,
  output logic [COUNT_WIDTH-1:0] bin_count_out,
  output logic                   bin_valid_out,
  input  logic                   bin_ready_in,
  output logic                   busy_out,
  output logic                   done_out
);

  localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(TABLE_SIZE - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, FLUSH, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [COUNT_WIDTH-1:0] mem [TABLE_SIZE];
  logic [IDX_W-1:0]       idx;
  logic                   flush_second;
  logic                   s1_valid;
  logic [IDX_W-1:0]       s1_addr;
  logic [COUNT_WIDTH-1:0] rd_data;
  logic                   beat_valid;
  logic                   done_q;

  logic                   accept;
  logic [IDX_W-1:0]       pix_idx;
  logic [COUNT_WIDTH-1:0] s1_inc;
  logic                   skip;
  logic                   beat_done;
  logic                   rd_en;
  logic [IDX_W-1:0]       rd_addr;
  logic                   wr_en;
  logic [IDX_W-1:0]       wr_addr;
  logic [COUNT_WIDTH-1:0] wr_data;

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    pix_ready_out = (state == ACCUM);
    busy_out      = (state != IDLE);
    accept        = pix_valid_in && pix_ready_out;
    case (state)
      IDLE:  if (start_in && !done_q) state_nxt = CLEAR;
      CLEAR: if (idx == LAST_IDX) state_nxt = ACCUM;
      ACCUM: if (accept && pix_last_in) state_nxt = FLUSH;
      FLUSH: if (flush_second) state_nxt = DRAIN;
      DRAIN: if (beat_done && idx == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rd_data already carries any forwarded value, so S1 just increments it.
  always_comb begin
    pix_idx = IDX_W'(pix_in);
    s1_inc  = (rd_data == COUNT_MAX) ? rd_data : rd_data + 1'b1;
`ifdef HIST_SKIP_ZERO_EN
    skip    = beat_valid && (rd_data == '0);
`else
    skip    = 1'b0;
`endif
    bin_valid_out = beat_valid && !skip;
    bin_idx_out   = beat_valid ? idx : '0;
    bin_count_out = beat_valid ? rd_data : '0;
    beat_done     = beat_valid && (bin_ready_in || skip);
    if (state == ACCUM) begin
      rd_en   = accept;
      rd_addr = pix_idx;
    end else begin
      rd_en   = (state == DRAIN) && (!beat_valid || (beat_done && idx != LAST_IDX));
      rd_addr = beat_valid ? idx + 1'b1 : idx;
    end
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = idx;
      wr_data = '0;
    end else begin
      wr_en   = s1_valid;
      wr_addr = s1_addr;
      wr_data = s1_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Same-address back-to-back pixels take the S1 result, since memory is written on the same edge.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      idx          <= '0;
      flush_second <= 1'b0;
      s1_valid     <= 1'b0;
      s1_addr      <= '0;
      rd_data      <= '0;
      beat_valid   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      s1_valid     <= accept;
      if (accept) s1_addr <= pix_idx;
      if (rd_en) rd_data <= (accept && s1_valid && s1_addr == pix_idx) ? s1_inc : mem[rd_addr];
      flush_second <= (state == FLUSH) ? !flush_second : 1'b0;
      done_q       <= (state == DRAIN) && (state_nxt == IDLE);
      case (state)
        IDLE:  idx <= '0;
        CLEAR: idx <= idx + 1'b1;
        DRAIN: if (beat_done && idx != LAST_IDX) idx <= idx + 1'b1;
        default: idx <= idx;
      endcase
      if (state != DRAIN)                      beat_valid <= 1'b0;
      else if (!beat_valid)                    beat_valid <= 1'b1;
      else if (beat_done && idx == LAST_IDX)   beat_valid <= 1'b0;
    end
  end

  assign done_out = done_q;

endmodule

// File: tb/tb_histogram_sequencer.sv
// Directed bench for histogram_sequencer: full-size instance plus a 16-bin, 4-bit-count instance for saturation.
module tb_histogram_sequencer;

`ifdef HIST_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  pix = '0;
  logic        pix_valid = 1'b0;
  logic        pix_last = 1'b0;
  logic        pix_ready;
  logic [7:0]  bin_idx;
  logic [31:0] bin_count;
  logic        bin_valid;
  logic        bin_ready = 1'b1;
  logic        busy;
  logic        done;

  logic        start_s = 1'b0;
  logic [3:0]  pix_s = '0;
  logic        pix_valid_s = 1'b0;
  logic        pix_last_s = 1'b0;
  logic        ready_s;
  logic [3:0]  idx_s;
  logic [3:0]  cnt_s;
  logic        valid_s;
  logic        bin_ready_s = 1'b1;
  logic        busy_s;
  logic        done_s;

  int tests = 0;
  int fails = 0;
  int stalls = 0;
  int model [256];

  always #5 clk = ~clk;

  histogram_sequencer dut (
    .clk(clk), .rst_n_in(rst_n), .start_in(start), .pix_in(pix), .pix_valid_in(pix_valid),
    .pix_last_in(pix_last), .pix_ready_out(pix_ready), .bin_idx_out(bin_idx),
    .bin_count_out(bin_count), .bin_valid_out(bin_valid), .bin_ready_in(bin_ready),
    .busy_out(busy), .done_out(done)
  );

  histogram_sequencer #(.TABLE_SIZE(16), .DATA_WIDTH(4), .COUNT_WIDTH(4)) dut_small (
    .clk(clk), .rst_n_in(rst_n), .start_in(start_s), .pix_in(pix_s), .pix_valid_in(pix_valid_s),
    .pix_last_in(pix_last_s), .pix_ready_out(ready_s), .bin_idx_out(idx_s),
    .bin_count_out(cnt_s), .bin_valid_out(valid_s), .bin_ready_in(bin_ready_s),
    .busy_out(busy_s), .done_out(done_s)
  );

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic start_frame();
    int n = 0;
    for (int i = 0; i < 256; i++) model[i] = 0;
    stalls = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("busy_after_start", busy, 1);
    while (!pix_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_output("clear_to_accum", pix_ready, 1);
  endtask

  task automatic send_pix(input int v, input bit last);
    pix       = 8'(v);
    pix_valid = 1'b1;
    pix_last  = last;
    if (!pix_ready) stalls++;
    model[v]++;
    @(negedge clk);
    if (last) begin
      pix_valid = 1'b0;
      pix_last  = 1'b0;
    end
  endtask

  // Walks the drain stream against the model; toggle=1 alternates bin_ready every cycle.
  task automatic drain_check(input bit toggle);
    int          next_idx = 0;
    int          beats = 0;
    int          exp_beats = 0;
    int          cyc = 0;
    bit          got_done = 1'b0;
    bit          hold = 1'b0;
    bit          rdy;
    logic [7:0]  h_idx = '0;
    logic [31:0] h_cnt = '0;
    for (int i = 0; i < 256; i++) if (!SKIP || model[i] != 0) exp_beats++;
    while (!got_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        check_output("hold_valid", bin_valid, 1);
        check_output("hold_idx", bin_idx, h_idx);
        check_output("hold_count", bin_count, h_cnt);
      end
      hold = 1'b0;
      if (done) begin
        got_done = 1'b1;
        check_output("busy_at_done", busy, 0);
      end else begin
        rdy = toggle ? ((cyc % 2) == 1) : 1'b1;
        bin_ready = rdy;
        if (bin_valid) begin
          if (rdy) begin
            while (SKIP && next_idx < 255 && model[next_idx] == 0) next_idx++;
            check_output("beat_idx", bin_idx, next_idx);
            check_output("beat_count", bin_count, model[next_idx]);
            next_idx++;
            beats++;
          end else begin
            hold  = 1'b1;
            h_idx = bin_idx;
            h_cnt = bin_count;
          end
        end
      end
    end
    bin_ready = 1'b1;
    check_output("drain_done", got_done, 1);
    check_output("drain_beats", beats, exp_beats);
    @(negedge clk);
    check_output("done_single", done, 0);
  endtask

  initial begin
    int n;
    int beats_s;
    int c9;
    int other_nz;
    int stalls_s;
    bit seen;
    repeat (3) @(negedge clk);
    check_output("rst_ready", pix_ready, 0);
    check_output("rst_valid", bin_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_idx", bin_idx, 0);
    check_output("rst_count", bin_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Pixels {3,3,3,7}: bin3=3, bin7=1, forwarded back-to-back.
    start_frame();
    send_pix(3, 0); send_pix(3, 0); send_pix(3, 0); send_pix(7, 1);
    check_output("f1_stalls", stalls, 0);
    drain_check(1'b0);

    // 1000 equal pixels, then a drain with ready toggling.
    start_frame();
    for (int i = 0; i < 1000; i++) send_pix(8'h55, i == 999);
    check_output("f2_stalls", stalls, 0);
    drain_check(1'b1);

    // Two frames in a row: the second must not see the first's counts.
    start_frame();
    send_pix(1, 0); send_pix(1, 1);
    drain_check(1'b0);
    start_frame();
    send_pix(2, 1);
    drain_check(1'b0);

    start_frame();
    send_pix(4, 0); send_pix(200, 1);
    drain_check(1'b0);

    // Small instance: 20 pixels of 9 saturate a 4-bit counter; start mid-frame is ignored.
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    n = 0;
    while (!ready_s && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_output("s_clear_to_accum", ready_s, 1);
    stalls_s = 0;
    for (int i = 0; i < 20; i++) begin
      pix_s = 4'd9;
      pix_valid_s = 1'b1;
      pix_last_s = (i == 19);
      start_s = (i == 10);
      if (!ready_s) stalls_s++;
      @(negedge clk);
    end
    pix_valid_s = 1'b0;
    pix_last_s = 1'b0;
    start_s = 1'b0;
    check_output("s_stalls", stalls_s, 0);
    check_output("s_busy", busy_s, 1);
    n = 0; beats_s = 0; c9 = -1; other_nz = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (done_s) seen = 1'b1;
      if (valid_s) begin
        beats_s++;
        if (idx_s == 4'd9) c9 = int'(cnt_s);
        else if (cnt_s != 0) other_nz++;
      end
    end
    check_output("s_done", seen, 1);
    check_output("s_bin9", c9, 15);
    check_output("s_other_zero", other_nz, 0);
    check_output("s_beats", beats_s, SKIP ? 1 : 16);

    // Reset during DRAIN: outputs drop immediately and no done follows.
    start_frame();
    send_pix(5, 1);
    n = 0;
    while (!bin_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("mid_drain_reach", bin_valid, 1);
    check_output("mid_drain_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_valid", bin_valid, 0);
    check_output("mid_rst_idx", bin_idx, 0);
    check_output("mid_rst_count", bin_count, 0);
    check_output("mid_rst_busy", busy, 0);
    check_output("mid_rst_ready", pix_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check_output("mid_rst_no_done", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
